// File: rtl/mem_axi_remap_slice.sv
// mem_axi_remap_slice: registered AXI4 AR/AW stage with DRAM window remap, outstanding caps and quiesce/drain
//   clk_i, reset_i               clock, synchronous active-high reset
//   quiesce_i                    blocks new AR/AW acceptance; idle_o reports drained
//   s_ar_* / m_ar_*              upstream / downstream read address (2-entry slice)
//   s_aw_* / m_aw_*              upstream / downstream write address (2-entry slice)
//   s_w_* / m_w_*                write data, combinational pass-through
//   m_r_* / s_r_*                read data, combinational pass-through
//   m_b_* / s_b_*                write response, combinational pass-through
//   rd_outstanding_o / wr_outstanding_o   accepted but not yet completed transactions
//   idle_o, proto_err_o          drained indication, sticky completion-underflow flag
module mem_axi_remap_slice_buf #(
   parameter int W = 63
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         s_valid_i,
   input  logic         s_ready_i,
   input  logic [W-1:0] s_data_i,
   output logic         m_valid_o,
   input  logic         m_ready_i,
   output logic [W-1:0] m_data_o,
   output logic         skid_valid_o
);
   logic         out_v_q, out_v_d, skid_v_q, skid_v_d;
   logic [W-1:0] out_q, out_d, skid_q, skid_d;
   logic         s_hs, m_hs;
   assign s_hs = s_valid_i && s_ready_i;
   assign m_hs = out_v_q && m_ready_i;
   // s_ready excludes a full skid, so a skid refill never collides with an input beat
   always_comb begin
      out_v_d = out_v_q;
      out_d = out_q;
      skid_v_d = skid_v_q;
      skid_d = skid_q;
      if (m_hs) out_v_d = 1'b0;
      if (m_hs && skid_v_q) begin
         out_v_d = 1'b1;
         out_d = skid_q;
         skid_v_d = 1'b0;
      end
      if (s_hs) begin
         if (!out_v_q || m_hs) begin
            out_v_d = 1'b1;
            out_d = s_data_i;
         end else begin
            skid_v_d = 1'b1;
            skid_d = s_data_i;
         end
      end
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         out_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         out_q <= '0;
         skid_q <= '0;
      end else begin
         out_v_q <= out_v_d;
         skid_v_q <= skid_v_d;
         out_q <= out_d;
         skid_q <= skid_d;
      end
   end
   assign m_valid_o = out_v_q;
   assign m_data_o = out_q;
   assign skid_valid_o = skid_v_q;
endmodule

module mem_axi_remap_slice #(
   parameter int         ADDR_W    = 32,
   parameter int         DATA_W    = 64,
   parameter int         ID_W      = 6,
   parameter logic [3:0] REMAP_SEL = 4'd2,
   parameter logic [3:0] REMAP_HI  = 4'd4,
   parameter logic [3:0] REMAP_LO  = 4'd1,
   parameter int         MAX_OUT   = 8,
   parameter int         CNT_W     = 8
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                quiesce_i,
   input  logic                s_ar_valid_i,
   output logic                s_ar_ready_o,
   input  logic [ADDR_W-1:0]   s_ar_addr_i,
   input  logic [30:0]         s_ar_ctrl_i,
   output logic                m_ar_valid_o,
   input  logic                m_ar_ready_i,
   output logic [ADDR_W-1:0]   m_ar_addr_o,
   output logic [30:0]         m_ar_ctrl_o,
   input  logic                s_aw_valid_i,
   output logic                s_aw_ready_o,
   input  logic [ADDR_W-1:0]   s_aw_addr_i,
   input  logic [30:0]         s_aw_ctrl_i,
   output logic                m_aw_valid_o,
   input  logic                m_aw_ready_i,
   output logic [ADDR_W-1:0]   m_aw_addr_o,
   output logic [30:0]         m_aw_ctrl_o,
   input  logic                s_w_valid_i,
   input  logic [DATA_W-1:0]   s_w_data_i,
   input  logic [DATA_W/8-1:0] s_w_strb_i,
   input  logic                s_w_last_i,
   output logic                s_w_ready_o,
   output logic                m_w_valid_o,
   output logic [DATA_W-1:0]   m_w_data_o,
   output logic [DATA_W/8-1:0] m_w_strb_o,
   output logic                m_w_last_o,
   input  logic                m_w_ready_i,
   input  logic                m_r_valid_i,
   input  logic [ID_W-1:0]     m_r_id_i,
   input  logic [1:0]          m_r_resp_i,
   input  logic [DATA_W-1:0]   m_r_data_i,
   input  logic                m_r_last_i,
   output logic                m_r_ready_o,
   output logic                s_r_valid_o,
   output logic [ID_W-1:0]     s_r_id_o,
   output logic [1:0]          s_r_resp_o,
   output logic [DATA_W-1:0]   s_r_data_o,
   output logic                s_r_last_o,
   input  logic                s_r_ready_i,
   input  logic                m_b_valid_i,
   input  logic [ID_W-1:0]     m_b_id_i,
   input  logic [1:0]          m_b_resp_i,
   output logic                m_b_ready_o,
   output logic                s_b_valid_o,
   output logic [ID_W-1:0]     s_b_id_o,
   output logic [1:0]          s_b_resp_o,
   input  logic                s_b_ready_i,
   output logic [CNT_W-1:0]    rd_outstanding_o,
   output logic [CNT_W-1:0]    wr_outstanding_o,
   output logic                idle_o,
   output logic                proto_err_o
);
   localparam int PW = ADDR_W + 31;
   function automatic logic [ADDR_W-1:0] remap(input logic [ADDR_W-1:0] a);
      remap = {(a[ADDR_W-1 -: 4] == REMAP_SEL) ? REMAP_HI : REMAP_LO, a[ADDR_W-5:0]};
   endfunction
   logic             rdy_en_q;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
   logic             err_q, err_d, idle_q, idle_d;
   logic             ar_skid_v, aw_skid_v, ar_hs, aw_hs, r_done, b_done;
   logic [PW-1:0]    ar_out, aw_out;
   // rdy_en_q keeps the ready outputs low throughout reset without a combinational reset path
   assign s_ar_ready_o = rdy_en_q && !ar_skid_v && !quiesce_i && (rd_cnt_q < CNT_W'(MAX_OUT));
   assign s_aw_ready_o = rdy_en_q && !aw_skid_v && !quiesce_i && (wr_cnt_q < CNT_W'(MAX_OUT));
   assign ar_hs = s_ar_valid_i && s_ar_ready_o;
   assign aw_hs = s_aw_valid_i && s_aw_ready_o;
   assign r_done = m_r_valid_i && s_r_ready_i && m_r_last_i;
   assign b_done = m_b_valid_i && s_b_ready_i;
   mem_axi_remap_slice_buf #(.W(PW)) u_ar (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .s_valid_i    (s_ar_valid_i),
      .s_ready_i    (s_ar_ready_o),
      .s_data_i     ({remap(s_ar_addr_i), s_ar_ctrl_i}),
      .m_valid_o    (m_ar_valid_o),
      .m_ready_i    (m_ar_ready_i),
      .m_data_o     (ar_out),
      .skid_valid_o (ar_skid_v)
   );
   mem_axi_remap_slice_buf #(.W(PW)) u_aw (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .s_valid_i    (s_aw_valid_i),
      .s_ready_i    (s_aw_ready_o),
      .s_data_i     ({remap(s_aw_addr_i), s_aw_ctrl_i}),
      .m_valid_o    (m_aw_valid_o),
      .m_ready_i    (m_aw_ready_i),
      .m_data_o     (aw_out),
      .skid_valid_o (aw_skid_v)
   );
   assign {m_ar_addr_o, m_ar_ctrl_o} = ar_out;
   assign {m_aw_addr_o, m_aw_ctrl_o} = aw_out;
   // a completion arriving with nothing outstanding is an underflow: count floors at 0, error sticks
   always_comb begin
      rd_cnt_d = (ar_hs && !r_done) ? rd_cnt_q + CNT_W'(1) :
                 (r_done && !ar_hs && rd_cnt_q != '0) ? rd_cnt_q - CNT_W'(1) : rd_cnt_q;
      wr_cnt_d = (aw_hs && !b_done) ? wr_cnt_q + CNT_W'(1) :
                 (b_done && !aw_hs && wr_cnt_q != '0) ? wr_cnt_q - CNT_W'(1) : wr_cnt_q;
      err_d = err_q || (r_done && rd_cnt_q == '0) || (b_done && wr_cnt_q == '0);
      idle_d = quiesce_i && rd_cnt_q == '0 && wr_cnt_q == '0 &&
               !m_ar_valid_o && !ar_skid_v && !m_aw_valid_o && !aw_skid_v;
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rdy_en_q <= 1'b0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         err_q <= 1'b0;
         idle_q <= 1'b0;
      end else begin
         rdy_en_q <= 1'b1;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         err_q <= err_d;
         idle_q <= idle_d;
      end
   end
   assign rd_outstanding_o = rd_cnt_q;
   assign wr_outstanding_o = wr_cnt_q;
   assign proto_err_o = err_q;
   assign idle_o = idle_q;
   assign s_w_ready_o = m_w_ready_i;
   assign m_w_valid_o = s_w_valid_i;
   assign m_w_data_o = s_w_data_i;
   assign m_w_strb_o = s_w_strb_i;
   assign m_w_last_o = s_w_last_i;
   assign m_r_ready_o = s_r_ready_i;
   assign s_r_valid_o = m_r_valid_i;
   assign s_r_id_o = m_r_id_i;
   assign s_r_resp_o = m_r_resp_i;
   assign s_r_data_o = m_r_data_i;
   assign s_r_last_o = m_r_last_i;
   assign m_b_ready_o = s_b_ready_i;
   assign s_b_valid_o = m_b_valid_i;
   assign s_b_id_o = m_b_id_i;
   assign s_b_resp_o = m_b_resp_i;
endmodule

// File: tb/tb_mem_axi_remap_slice.sv
// tb_mem_axi_remap_slice: directed self-checking bench for mem_axi_remap_slice
module tb_mem_axi_remap_slice;
   logic        clk = 1'b0, reset = 1'b1, quiesce = 1'b0;
   logic        s_ar_valid = 0, s_ar_ready, m_ar_valid, m_ar_ready = 0;
   logic [31:0] s_ar_addr = 0, m_ar_addr;
   logic [30:0] s_ar_ctrl = 0, m_ar_ctrl;
   logic        s_aw_valid = 0, s_aw_ready, m_aw_valid, m_aw_ready = 0;
   logic [31:0] s_aw_addr = 0, m_aw_addr;
   logic [30:0] s_aw_ctrl = 0, m_aw_ctrl;
   logic        s_w_valid = 0, s_w_last = 0, s_w_ready, m_w_valid, m_w_last, m_w_ready = 0;
   logic [63:0] s_w_data = 0, m_w_data;
   logic [7:0]  s_w_strb = 0, m_w_strb;
   logic        m_r_valid = 0, m_r_last = 0, m_r_ready, s_r_valid, s_r_last, s_r_ready = 0;
   logic [5:0]  m_r_id = 0, s_r_id;
   logic [1:0]  m_r_resp = 0, s_r_resp;
   logic [63:0] m_r_data = 0, s_r_data;
   logic        m_b_valid = 0, m_b_ready, s_b_valid, s_b_ready = 0;
   logic [5:0]  m_b_id = 0, s_b_id;
   logic [1:0]  m_b_resp = 0, s_b_resp;
   logic [7:0]  rd_out, wr_out;
   logic        idle, proto_err;
   int          n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   mem_axi_remap_slice dut (
      .clk_i(clk), .reset_i(reset), .quiesce_i(quiesce),
      .s_ar_valid_i(s_ar_valid), .s_ar_ready_o(s_ar_ready), .s_ar_addr_i(s_ar_addr), .s_ar_ctrl_i(s_ar_ctrl),
      .m_ar_valid_o(m_ar_valid), .m_ar_ready_i(m_ar_ready), .m_ar_addr_o(m_ar_addr), .m_ar_ctrl_o(m_ar_ctrl),
      .s_aw_valid_i(s_aw_valid), .s_aw_ready_o(s_aw_ready), .s_aw_addr_i(s_aw_addr), .s_aw_ctrl_i(s_aw_ctrl),
      .m_aw_valid_o(m_aw_valid), .m_aw_ready_i(m_aw_ready), .m_aw_addr_o(m_aw_addr), .m_aw_ctrl_o(m_aw_ctrl),
      .s_w_valid_i(s_w_valid), .s_w_data_i(s_w_data), .s_w_strb_i(s_w_strb), .s_w_last_i(s_w_last),
      .s_w_ready_o(s_w_ready), .m_w_valid_o(m_w_valid), .m_w_data_o(m_w_data), .m_w_strb_o(m_w_strb),
      .m_w_last_o(m_w_last), .m_w_ready_i(m_w_ready),
      .m_r_valid_i(m_r_valid), .m_r_id_i(m_r_id), .m_r_resp_i(m_r_resp), .m_r_data_i(m_r_data),
      .m_r_last_i(m_r_last), .m_r_ready_o(m_r_ready), .s_r_valid_o(s_r_valid), .s_r_id_o(s_r_id),
      .s_r_resp_o(s_r_resp), .s_r_data_o(s_r_data), .s_r_last_o(s_r_last), .s_r_ready_i(s_r_ready),
      .m_b_valid_i(m_b_valid), .m_b_id_i(m_b_id), .m_b_resp_i(m_b_resp), .m_b_ready_o(m_b_ready),
      .s_b_valid_o(s_b_valid), .s_b_id_o(s_b_id), .s_b_resp_o(s_b_resp), .s_b_ready_i(s_b_ready),
      .rd_outstanding_o(rd_out), .wr_outstanding_o(wr_out), .idle_o(idle), .proto_err_o(proto_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain_r(input int n);
      m_r_valid = 1; m_r_last = 1; s_r_ready = 1;
      repeat (n) tick();
      m_r_valid = 0;
   endtask

   task automatic drain_b(input int n);
      m_b_valid = 1; s_b_ready = 1;
      repeat (n) tick();
      m_b_valid = 0;
   endtask

   // source address alternates between the high-window nibble 2 and an ordinary nibble 3
   function automatic logic [31:0] src(input int i);
      src = ((i % 2) != 0 ? 32'h3000_0000 : 32'h2000_0000) | (32'(i) << 4);
   endfunction

   function automatic logic [62:0] exp_ar(input int i);
      exp_ar = {((i % 2) != 0 ? 32'h1000_0000 : 32'h4000_0000) | (32'(i) << 4), 31'h1234_0000 ^ 31'(i)};
   endfunction

   initial begin
      int sent, got, viol, acc;
      logic prev_stall;
      logic [62:0] prev_val;
      // reset state
      tick(); tick();
      chk("rst_outs", {m_ar_valid, m_aw_valid, s_ar_ready, s_aw_ready, idle, proto_err}, 6'b0);
      chk("rst_cnt", {rd_out, wr_out}, 16'h0);
      reset = 0;
      tick();
      chk("rst_rdy", {s_ar_ready, s_aw_ready}, 2'b11);
      // remap with downstream stalled: one-cycle latency, output held
      s_ar_valid = 1; s_ar_addr = 32'h2000_1000; s_ar_ctrl = 31'h5A5A_1234;
      tick(); s_ar_valid = 0;
      chk("remap_ar_hi", {m_ar_valid, m_ar_addr, m_ar_ctrl}, {1'b1, 32'h4000_1000, 31'h5A5A_1234});
      tick();
      chk("ar_hold", {m_ar_valid, m_ar_addr}, {1'b1, 32'h4000_1000});
      m_ar_ready = 1; tick();
      chk("ar_consumed", m_ar_valid, 1'b0);
      s_ar_valid = 1; s_ar_addr = 32'hF000_0004; s_ar_ctrl = 31'h7FFF_FFFF;
      tick(); s_ar_valid = 0;
      chk("remap_ar_lo", {m_ar_valid, m_ar_addr, m_ar_ctrl}, {1'b1, 32'h1000_0004, 31'h7FFF_FFFF});
      s_aw_valid = 1; s_aw_addr = 32'h0123_4560; s_aw_ctrl = 31'h0000_0F0F;
      tick(); s_aw_valid = 0;
      chk("remap_aw", {m_aw_valid, m_aw_addr, m_aw_ctrl}, {1'b1, 32'h1123_4560, 31'h0000_0F0F});
      m_aw_ready = 1; tick();
      chk("cnt_after_remap", {rd_out, wr_out}, {8'd2, 8'd1});
      // pass-through channels
      s_w_valid = 1; s_w_data = 64'hDEAD_BEEF_0123_4567; s_w_strb = 8'hA5; s_w_last = 1; m_w_ready = 1;
      m_r_id = 6'h2A; m_r_resp = 2'b10; m_r_data = 64'hCAFE_F00D_8765_4321; s_r_ready = 1;
      m_b_id = 6'h15; m_b_resp = 2'b01; s_b_ready = 0;
      #1;
      chk("w_pass", {m_w_valid, m_w_last, m_w_strb, s_w_ready}, {1'b1, 1'b1, 8'hA5, 1'b1});
      chk("w_data", m_w_data, 64'hDEAD_BEEF_0123_4567);
      chk("r_data", s_r_data, 64'hCAFE_F00D_8765_4321);
      chk("rb_side", {s_r_id, s_r_resp, m_r_ready, s_b_id, s_b_resp, m_b_ready}, {6'h2A, 2'b10, 1'b1, 6'h15, 2'b01, 1'b0});
      m_w_ready = 0; s_w_valid = 0; #1;
      chk("w_ready_low", {s_w_ready, m_w_valid}, 2'b00);
      drain_r(2); drain_b(1);
      chk("cnt_drained", {rd_out, wr_out, proto_err}, {8'd0, 8'd0, 1'b0});
      // backpressure: 16 beats, random downstream ready, in-order and stable
      sent = 0; got = 0; viol = 0; prev_stall = 0; prev_val = '0;
      for (int c = 0; c < 400 && got < 16; c++) begin
         s_ar_valid = sent < 16; s_ar_addr = src(sent); s_ar_ctrl = 31'h1234_0000 ^ 31'(sent);
         m_ar_ready = 1'($urandom_range(0, 1));
         m_r_valid = rd_out != 0; m_r_last = 1; s_r_ready = 1;
         #1;
         if (prev_stall && (!m_ar_valid || {m_ar_addr, m_ar_ctrl} != prev_val)) viol++;
         if (m_ar_valid && m_ar_ready) begin
            chk("bp_order", {1'b0, m_ar_addr, m_ar_ctrl}, {1'b0, exp_ar(got)});
            got++;
         end
         prev_stall = m_ar_valid && !m_ar_ready;
         prev_val = {m_ar_addr, m_ar_ctrl};
         if (s_ar_valid && s_ar_ready) sent++;
         tick();
      end
      s_ar_valid = 0; m_ar_ready = 1;
      chk("bp_count", 64'(got), 64'd16);
      chk("bp_stable", 64'(viol), 64'd0);
      for (int c = 0; c < 20 && rd_out != 0; c++) begin
         m_r_valid = 1; tick();
      end
      m_r_valid = 0; tick();
      chk("bp_tail", {m_ar_valid, rd_out, proto_err}, {1'b0, 8'd0, 1'b0});
      // full rate: one beat out per cycle after one cycle
      for (int k = 0; k < 4; k++) begin
         s_ar_valid = 1; s_ar_addr = src(k + 20); s_ar_ctrl = 31'h1234_0000 ^ 31'(k + 20);
         #1;
         chk("fr_ready", s_ar_ready, 1'b1);
         tick();
         chk("fr_out", {m_ar_valid, m_ar_addr, m_ar_ctrl}, {1'b1, exp_ar(k + 20)});
      end
      s_ar_valid = 0; tick();
      chk("fr_cnt", {m_ar_valid, rd_out}, {1'b0, 8'd4});
      drain_r(4);
      // outstanding cap at 8
      acc = 0; s_ar_valid = 1; s_ar_addr = 32'h2000_0040;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (s_ar_ready) acc++;
         tick();
      end
      chk("cap_acc", 64'(acc), 64'd8);
      chk("cap_state", {s_ar_ready, rd_out}, {1'b0, 8'd8});
      m_r_valid = 1; m_r_last = 1; s_r_ready = 1; tick(); m_r_valid = 0;
      chk("cap_dec", {s_ar_ready, rd_out}, {1'b1, 8'd7});
      tick();
      chk("cap_ninth", {s_ar_ready, rd_out}, {1'b0, 8'd8});
      s_ar_valid = 0; drain_r(8);
      chk("cap_drain", rd_out, 8'd0);
      // simultaneous AW accept and B completion
      s_aw_valid = 1; s_aw_addr = 32'h2000_0000; repeat (3) tick(); s_aw_valid = 0;
      chk("sim_pre", wr_out, 8'd3);
      s_aw_valid = 1; m_b_valid = 1; s_b_ready = 1; #1;
      chk("sim_rdy", s_aw_ready, 1'b1);
      tick(); s_aw_valid = 0; m_b_valid = 0;
      chk("sim_cnt", wr_out, 8'd3);
      drain_b(3);
      chk("b_drained", {wr_out, proto_err}, {8'd0, 1'b0});
      drain_b(1);
      chk("b_underflow", {wr_out, proto_err}, {8'd0, 1'b1});
      repeat (3) tick();
      chk("err_sticky", proto_err, 1'b1);
      // quiesce and drain
      reset = 1; tick(); reset = 0; tick();
      chk("err_cleared", proto_err, 1'b0);
      s_ar_valid = 1; repeat (3) tick(); s_ar_valid = 0; tick();
      chk("q_pre", rd_out, 8'd3);
      quiesce = 1; tick();
      chk("q_block", {s_ar_ready, s_aw_ready, idle}, 3'b000);
      drain_r(3);
      chk("q_lastr", {rd_out, idle}, {8'd0, 1'b0});
      tick();
      chk("q_idle", idle, 1'b1);
      quiesce = 0; tick();
      chk("q_release", {idle, s_ar_ready, s_aw_ready}, 3'b011);
      // reset with both slices full and counters at 5
      drain_r(1);
      chk("r_underflow", proto_err, 1'b1);
      m_ar_ready = 1; m_aw_ready = 1; s_ar_valid = 1; s_aw_valid = 1;
      repeat (4) tick();
      m_ar_ready = 0; m_aw_ready = 0; tick();
      s_ar_valid = 0; s_aw_valid = 0;
      chk("full_pre", {rd_out, wr_out, m_ar_valid, m_aw_valid, s_ar_ready, s_aw_ready}, {8'd5, 8'd5, 4'b1100});
      reset = 1; tick();
      chk("mid_rst", {m_ar_valid, m_aw_valid, rd_out, wr_out, proto_err, s_ar_ready}, {2'b00, 16'h0, 2'b00});
      reset = 0; tick(); tick();
      chk("post_rst", {m_ar_valid, m_aw_valid, s_ar_ready, s_aw_ready}, 4'b0011);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
